// File: rtl/capture_pkg.sv
// Shared types and constants for the DSO capture controller.
// The controller walks IDLE -> PRE -> ARMED -> POST -> IDLE; the trigger
// mode field of trig_cfg selects autoroll, normal or off.
package capture_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        ARMED = 2'd2,
        POST  = 2'd3
    } cap_state_t;

    localparam logic [1:0] MODE_AUTO = 2'b10;
    localparam logic [1:0] MODE_NORM = 2'b01;

    // A capture may only run while the mode field selects autoroll or normal.
    function automatic logic mode_active(input logic [1:0] mode);
        return (mode == MODE_AUTO) || (mode == MODE_NORM);
    endfunction

endpackage

// File: rtl/capture_ctrl_p_if.sv
// Sample RAM write port driven by the capture controller: one shared write
// address, one write strobe per channel RAM and a common RAM enable.
interface capture_ctrl_p_if #(
    parameter int ADDR_W = 9,
    parameter int NUM_CH = 3
);

    logic [ADDR_W-1:0] addr;
    logic [NUM_CH-1:0] we;
    logic              en;

    modport master (output addr, we, en);
    modport slave  (input  addr, we, en);

endinterface

// File: rtl/dec_strobe.sv
// Sample-rate decimator: emits one strobe every 2^decimator_reg clocks while
// run is high. clr restarts the count so the first strobe of a capture lands
// exactly 2^decimator_reg clocks after the capture starts.
module dec_strobe #(
    parameter int DEC_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             run,
    input  logic [DEC_W-1:0] decimator_reg,
    output logic             strobe
);

    // Wide enough to count up to 2^(2^DEC_W - 1) - 1 for the largest exponent.
    localparam int CNT_W = (1 << DEC_W) - 1;

    logic [CNT_W-1:0] dec_cnt;
    logic [CNT_W:0]   period;
    logic [CNT_W-1:0] limit;

    // Terminal count is 2^decimator_reg - 1; exponent 0 gives a strobe every clk.
    always_comb begin
        period = {{CNT_W{1'b0}}, 1'b1} << decimator_reg;
        limit  = CNT_W'(period - {{CNT_W{1'b0}}, 1'b1});
        strobe = run && (dec_cnt == limit);
    end

    // Free-running counter that wraps to zero on every strobe.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            dec_cnt <= '0;
        end else if (run) begin
            if (strobe) begin
                dec_cnt <= '0;
            end else begin
                dec_cnt <= dec_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/capture_ctrl_p.sv
// Capture sequencer for a circular multi-channel sample RAM. Fills the
// pre-trigger window, arms, waits for a trigger (or forces one after an
// autoroll timeout), records the post-trigger window and reports where the
// trace ends. Dropping the trigger mode aborts a capture at any point.
module capture_ctrl_p
    import capture_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int NUM_CH = 3,
    parameter int DEC_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        trig_cfg,
    input  logic [ADDR_W-1:0] trig_pos,
    input  logic [DEC_W-1:0]  decimator_reg,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              triggered,
    input  logic              rd_busy,
    input  logic              clr_capture_done,
    output logic              trig_en,
    output logic              armed,
    output logic              capture_done,
    output logic              trig_forced,
    output logic [ADDR_W-1:0] trace_end,
    capture_ctrl_p_if.master  ram
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    cap_state_t        state;
    cap_state_t        state_next;

    logic [1:0]        mode;
    logic              mode_ok;
    logic              is_auto;
    logic              unused_cfg;

    logic              strobe;
    logic              run;

    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   smpl_cnt;
    logic [ADDR_W:0]   to_cnt;
    logic [ADDR_W-1:0] post_cnt;

    logic [ADDR_W:0]   pre_target;
    logic [ADDR_W:0]   smpl_cnt_inc;
    logic [ADDR_W:0]   to_cnt_inc;

    logic              start;
    logic              do_write;
    logic              arm_now;
    logic              force_now;
    logic              done_now;
    logic              abort;

    // Only the mode field of trig_cfg matters to the sequencer.
    assign mode       = trig_cfg[3:2];
    assign mode_ok    = mode_active(mode);
    assign is_auto    = (mode == MODE_AUTO);
    assign trig_en    = mode_ok;
    assign unused_cfg = ^{trig_cfg[7:4], trig_cfg[1:0]};

    assign run        = (state != IDLE);

    // The pre-trigger window is whatever part of the RAM the post window leaves.
    assign pre_target   = DEPTH - {1'b0, trig_pos};
    assign smpl_cnt_inc = smpl_cnt + (ADDR_W+1)'(1);
    assign to_cnt_inc   = to_cnt + (ADDR_W+1)'(1);

    dec_strobe #(
        .DEC_W(DEC_W)
    ) u_dec (
        .clk          (clk),
        .rst          (rst),
        .clr          (start),
        .run          (run),
        .decimator_reg(decimator_reg),
        .strobe       (strobe)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the per-cycle actions the datapath carries out.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        do_write   = 1'b0;
        arm_now    = 1'b0;
        force_now  = 1'b0;
        done_now   = 1'b0;
        abort      = 1'b0;

        case (state)
            IDLE: begin
                if (mode_ok && !rd_busy && !capture_done) begin
                    start      = 1'b1;
                    state_next = PRE;
                end
            end

            PRE: begin
                if (!mode_ok) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (strobe) begin
                    do_write = 1'b1;
                    if (smpl_cnt_inc == pre_target) begin
                        arm_now    = 1'b1;
                        state_next = ARMED;
                    end
                end
            end

            ARMED: begin
                if (!mode_ok) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else begin
                    do_write = strobe;
                    if (triggered) begin
                        state_next = POST;
                    end else if (is_auto && strobe && (to_cnt_inc == DEPTH)) begin
                        force_now  = 1'b1;
                        state_next = POST;
                    end
                end
            end

            POST: begin
                if (!mode_ok) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (post_cnt == trig_pos) begin
                    done_now   = 1'b1;
                    state_next = IDLE;
                end else if (strobe) begin
                    do_write = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // RAM write port: every enabled channel is strobed together at the shared address.
    always_comb begin
        ram.addr = addr;
        ram.we   = do_write ? ch_mask : '0;
        ram.en   = |ram.we;
    end

    // Address, window counters and the sticky status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr         <= '0;
            smpl_cnt     <= '0;
            to_cnt       <= '0;
            post_cnt     <= '0;
            armed        <= 1'b0;
            capture_done <= 1'b0;
            trig_forced  <= 1'b0;
            trace_end    <= '0;
        end else begin
            if (start) begin
                addr        <= '0;
                smpl_cnt    <= '0;
                to_cnt      <= '0;
                post_cnt    <= '0;
                trig_forced <= 1'b0;
                armed       <= 1'b0;
            end

            if (do_write) begin
                addr <= addr + ADDR_W'(1);
            end

            if (do_write && (state == PRE)) begin
                smpl_cnt <= smpl_cnt_inc;
            end

            if (do_write && (state == POST)) begin
                post_cnt <= post_cnt + ADDR_W'(1);
            end

            if ((state == ARMED) && is_auto && strobe) begin
                to_cnt <= to_cnt_inc;
            end

            if (arm_now) begin
                armed <= 1'b1;
            end

            if (force_now) begin
                trig_forced <= 1'b1;
            end

            if (done_now) begin
                trace_end <= addr - ADDR_W'(1);
            end

            if (done_now || abort) begin
                armed <= 1'b0;
            end

            if (done_now) begin
                capture_done <= 1'b1;
            end else if (clr_capture_done) begin
                capture_done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_capture_ctrl_p.sv
// Bench for capture_ctrl_p. Expected capture timing is derived from the
// capture rules directly: write j of a capture lands 2^dec*(j+1) clocks after
// the start cycle at address j mod DEPTH, arming, trigger acceptance, timeout
// and completion cycles follow from the window sizes.
module tb_capture_ctrl_p;

    localparam int ADDR_W = 9;
    localparam int NUM_CH = 3;
    localparam int DEC_W  = 4;
    localparam int D      = 1 << ADDR_W;
    localparam int NEVER  = 32'h7fffffff;
    localparam logic [1:0] M_AUTO = 2'b10;
    localparam logic [1:0] M_NORM = 2'b01;

    logic              clk;
    logic              rst;
    logic [7:0]        trig_cfg;
    logic [ADDR_W-1:0] trig_pos;
    logic [DEC_W-1:0]  decimator_reg;
    logic [NUM_CH-1:0] ch_mask;
    logic              triggered;
    logic              rd_busy;
    logic              clr_capture_done;
    logic              trig_en;
    logic              armed;
    logic              capture_done;
    logic              trig_forced;
    logic [ADDR_W-1:0] trace_end;

    capture_ctrl_p_if #(.ADDR_W(ADDR_W), .NUM_CH(NUM_CH)) ram_bus ();

    capture_ctrl_p #(
        .ADDR_W(ADDR_W),
        .NUM_CH(NUM_CH),
        .DEC_W (DEC_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .trig_cfg        (trig_cfg),
        .trig_pos        (trig_pos),
        .decimator_reg   (decimator_reg),
        .ch_mask         (ch_mask),
        .triggered       (triggered),
        .rd_busy         (rd_busy),
        .clr_capture_done(clr_capture_done),
        .trig_en         (trig_en),
        .armed           (armed),
        .capture_done    (capture_done),
        .trig_forced     (trig_forced),
        .trace_end       (trace_end),
        .ram             (ram_bus)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int armed_rise = -1;
    int done_rise  = -1;
    int last_trace = 0;

    int              cyc_q[$];
    logic [8:0]      addr_q[$];
    logic [2:0]      we_q[$];
    logic            en_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: log every RAM write and the first cycle armed / capture_done are seen high.
    always @(negedge clk) begin
        if (ram_bus.en || (ram_bus.we != '0)) begin
            cyc_q.push_back(cyc);
            addr_q.push_back(ram_bus.addr);
            we_q.push_back(ram_bus.we);
            en_q.push_back(ram_bus.en);
        end
        if (armed && (armed_rise < 0)) armed_rise = cyc;
        if (capture_done && (done_rise < 0)) done_rise = cyc;
    end

    // Bounded run time in case the design stalls in an unexpected way.
    initial begin
        #(10 * 99000);
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input longint actual, input longint expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clearLog();
        cyc_q.delete();
        addr_q.delete();
        we_q.delete();
        en_q.delete();
    endtask

    // Clear any previous result, program the capture, then raise the mode; returns the start cycle.
    task automatic startCapture(input logic [1:0] mode, input int d, input int p,
                                input logic [2:0] mask, output int s);
        tick();
        trig_cfg         = 8'($urandom) & 8'hF3;
        clr_capture_done = 1'b1;
        triggered        = 1'b0;
        rd_busy          = 1'b0;
        tick();
        clr_capture_done = 1'b0;
        decimator_reg    = DEC_W'(d);
        trig_pos         = ADDR_W'(p);
        ch_mask          = mask;
        tick();
        s = cyc;
        clearLog();
        armed_rise    = -1;
        done_rise     = -1;
        trig_cfg[3:2] = mode;
    endtask

    // Full capture against the timing model; trig_off is the trigger delay after arming, <0 for none.
    task automatic applyStimulus(input logic [1:0] mode, input int d, input int p,
                                 input logic [2:0] mask, input int trig_off,
                                 input bit noise, input bit clr_at_done, input string tag);
        int per, s, armed_cyc, t_trig, tf, end_c, a, total, done_c, limit, bad, nwr, exp_trace;
        bit forced;
        per = 1 << d;
        startCapture(mode, d, p, mask, s);

        armed_cyc = s + (D - p) * per + 1;
        t_trig    = (trig_off < 0) ? NEVER : armed_cyc + trig_off;
        tf        = (mode == M_AUTO) ? s + (2 * D - p) * per : NEVER;
        forced    = (tf < t_trig);
        end_c     = forced ? tf : t_trig;
        a         = (end_c - s) / per;
        total     = a + p;
        done_c    = ((p == 0) ? end_c : s + total * per) + 2;
        exp_trace = (total - 1) % D;
        limit     = done_c + 4;

        while (cyc < limit) begin
            tick();
            triggered        = (cyc == t_trig) ||
                               (noise && (cyc < armed_cyc) && ($urandom_range(0, 7) == 0));
            clr_capture_done = clr_at_done && (cyc == done_c - 1);
        end
        triggered        = 1'b0;
        clr_capture_done = 1'b0;

        nwr = cyc_q.size();
        bad = 0;
        for (int j = 0; j < nwr; j++) begin
            if ((j >= total) || (cyc_q[j] != s + (j + 1) * per) || (int'(addr_q[j]) != j % D) ||
                (we_q[j] != mask) || (en_q[j] != 1'b1))
                bad++;
        end

        checkOutput({tag, "_armed_at"}, armed_rise - s, armed_cyc - s);
        checkOutput({tag, "_nwrites"}, nwr, total);
        checkOutput({tag, "_badwrites"}, bad, 0);
        checkOutput({tag, "_done_at"}, done_rise - s, done_c - s);
        checkOutput({tag, "_done_end"}, capture_done, 1);
        checkOutput({tag, "_trace_end"}, trace_end, exp_trace);
        checkOutput({tag, "_forced"}, trig_forced, forced);
        checkOutput({tag, "_armed_end"}, armed, 0);
        last_trace = exp_trace;
    endtask

    // No writes for n cycles under the current inputs.
    task automatic quietCheck(input string tag, input int n);
        tick();
        clearLog();
        repeat (n) tick();
        @(negedge clk);
        #1;
        checkOutput(tag, cyc_q.size(), 0);
    endtask

    initial begin
        int s, armed_cyc, first_cyc, first_addr;
        logic [1:0] rmode;
        int rd, rp, roff;
        logic [2:0] rmask;

        rst              = 1'b1;
        trig_cfg         = 8'h00;
        trig_pos         = '0;
        decimator_reg    = '0;
        ch_mask          = '0;
        triggered        = 1'b0;
        rd_busy          = 1'b0;
        clr_capture_done = 1'b0;
        repeat (3) tick();

        checkOutput("reset_outputs",
                    {armed, capture_done, trig_forced, trace_end, ram_bus.addr, ram_bus.we, ram_bus.en}, 0);
        for (int m = 0; m < 4; m++) begin
            trig_cfg = (8'($urandom) & 8'hF3) | 8'(m << 2);
            #1;
            checkOutput($sformatf("trig_en_mode%0d", m), trig_en, (m == 2) || (m == 1));
        end
        trig_cfg = 8'h00;
        tick();
        rst = 1'b0;

        $display("[TB] normal capture, 600 strobes before trigger");
        applyStimulus(M_NORM, 0, 100, 3'b101, 187, 1'b1, 1'b0, "norm");

        $display("[TB] autoroll timeout, dec=2");
        applyStimulus(M_AUTO, 2, 50, 3'b011, -1, 1'b0, 1'b0, "auto");

        $display("[TB] trig_pos=0 with clear in the done cycle");
        applyStimulus(M_NORM, 0, 0, 3'b111, 37, 1'b1, 1'b1, "tp0");

        $display("[TB] start gating");
        quietCheck("done_gate_nowr", 20);
        checkOutput("done_gate_armed", armed, 0);
        trig_cfg[3:2]    = 2'b00;
        clr_capture_done = 1'b1;
        tick();
        clr_capture_done = 1'b0;
        tick();
        checkOutput("clr_done", capture_done, 0);
        rd_busy       = 1'b1;
        decimator_reg = '0;
        ch_mask       = 3'b111;
        trig_cfg[3:2] = M_NORM;
        quietCheck("busy_gate_nowr", 20);
        checkOutput("busy_gate_armed", armed, 0);
        trig_cfg[3:2] = 2'b00;
        tick();
        rd_busy = 1'b0;

        $display("[TB] abort while armed");
        startCapture(M_NORM, 0, 50, 3'b110, s);
        armed_cyc = s + (D - 50) + 1;
        while (cyc < armed_cyc + 10) tick();
        checkOutput("abort_armed_before", armed, 1);
        trig_cfg[3:2] = 2'b00;
        clearLog();
        tick();
        checkOutput("abort_armed", armed, 0);
        checkOutput("abort_done", capture_done, 0);
        checkOutput("abort_trace", trace_end, last_trace);
        repeat (5) tick();
        @(negedge clk);
        #1;
        checkOutput("abort_nowr", cyc_q.size(), 0);

        $display("[TB] reset during post-trigger capture");
        startCapture(M_AUTO, 0, 100, 3'b111, s);
        armed_cyc = s + (D - 100) + 1;
        while (cyc < armed_cyc + 3) tick();
        triggered = 1'b1;
        tick();
        triggered = 1'b0;
        repeat (20) tick();
        rst      = 1'b1;
        trig_cfg = 8'h00;
        tick();
        rst = 1'b0;
        #1;
        checkOutput("rst_post_outputs",
                    {armed, capture_done, trig_forced, trace_end, ram_bus.addr, ram_bus.we, ram_bus.en}, 0);
        last_trace = 0;
        repeat (10) tick();
        checkOutput("rst_post_no_done", capture_done, 0);

        $display("[TB] slowest decimation");
        startCapture(M_NORM, 15, 0, 3'b001, s);
        while (cyc < s + 32768 + 2) tick();
        @(negedge clk);
        #1;
        first_cyc  = (cyc_q.size() > 0) ? cyc_q[0] - s : -1;
        first_addr = (addr_q.size() > 0) ? int'(addr_q[0]) : -1;
        checkOutput("dec15_nwrites", cyc_q.size(), 1);
        checkOutput("dec15_first_at", first_cyc, 32768);
        checkOutput("dec15_first_addr", first_addr, 0);
        tick();
        trig_cfg[3:2] = 2'b00;
        tick();

        $display("[TB] randomized captures");
        for (int r = 0; r < 4; r++) begin
            rmode = ($urandom_range(0, 1) == 1) ? M_AUTO : M_NORM;
            rd    = $urandom_range(0, 2);
            rp    = $urandom_range(0, D - 1);
            rmask = 3'($urandom_range(1, 7));
            if (rmode == M_AUTO)
                roff = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, D * (1 << rd) + 20);
            else
                roff = $urandom_range(0, 300);
            $display("[TB] rand%0d mode=%0d dec=%0d pos=%0d mask=%0d off=%0d", r, rmode, rd, rp, rmask, roff);
            applyStimulus(rmode, rd, rp, rmask, roff, 1'b1, 1'b0, $sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
